// File: rtl/color_palette_router_if.sv
// Host write bus for the colour palette: nibble address/data with valid/ack.
interface color_palette_router_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        data;
  logic              valid;
  logic              ack;

  modport master (
    output address,
    output data,
    output valid,
    input  ack
  );

  modport slave (
    input  address,
    input  data,
    input  valid,
    output ack
  );
endinterface

// File: rtl/color_palette_router.sv
// Palette register file with nibble-wide host writes, per-channel palette
// selection, grid mirroring and output colour modes for the VGA path.
module color_palette_router #(
  parameter  int NUM_PAL = 8,
  parameter  int ROWS    = 2,
  parameter  int COLS    = 2,
  parameter  int COLOR_W = 8,
  localparam int PAL_W   = $clog2(NUM_PAL),
  localparam int NUM_CH  = ROWS * COLS,
  localparam int CH_W    = $clog2(NUM_CH),
  localparam int PIX_W   = 3 * COLOR_W,
  localparam int NIBS    = PIX_W / 4,
  localparam int NIB_W   = $clog2(NIBS),
  localparam int ADDR_W  = PAL_W + NIB_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_swap_h,
  input  logic                      i_swap_v,
  input  logic                      i_color_next,
  input  logic [CH_W-1:0]           i_channel,
  input  logic [1:0]                i_mode,
  color_palette_router_if.slave     bus,
  output logic [NUM_PAL*PIX_W-1:0]  o_pal_flat,
  output logic [NUM_CH*PIX_W-1:0]   o_ch_flat
);

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'd0,
    MODE_GRAY      = 2'd1,
    MODE_INVERT    = 2'd2,
    MODE_REPLICATE = 2'd3
  } mode_e;

  // Registered state
  logic                 r_ack;
  logic [PIX_W-1:0]     r_staging;
  logic [PIX_W-1:0]     r_pal [NUM_PAL];
  logic [PAL_W-1:0]     r_idx [NUM_CH];
  logic [PIX_W-1:0]     r_ch  [NUM_CH];
  logic                 r_flip_h;
  logic                 r_flip_v;
  logic                 r_swap_h_d;
  logic                 r_swap_v_d;
  logic                 r_color_next_d;

  // Combinational signals
  logic [PAL_W-1:0]     w_entry;
  logic [NIB_W-1:0]     w_nib;
  logic                 w_accept;
  logic                 w_nib_ok;
  logic                 w_last;
  logic [PIX_W-1:0]     w_merged;
  logic                 w_swap_h_rise;
  logic                 w_swap_v_rise;
  logic                 w_color_next_rise;
  mode_e                w_mode;
  logic [PIX_W-1:0]     w_raw [NUM_CH];
  logic [PIX_W-1:0]     w_out [NUM_CH];

  assign w_entry  = bus.address[ADDR_W-1 -: PAL_W];
  assign w_nib    = bus.address[NIB_W-1:0];
  assign w_accept = bus.valid & ~r_ack;
  assign w_nib_ok = ({1'b0, w_nib} < (NIB_W+1)'(NIBS));
  assign w_last   = (w_nib == NIB_W'(NIBS - 1));
  assign w_mode   = mode_e'(i_mode);
  assign bus.ack  = r_ack;

  assign w_swap_h_rise     = i_swap_h     & ~r_swap_h_d;
  assign w_swap_v_rise     = i_swap_v     & ~r_swap_v_d;
  assign w_color_next_rise = i_color_next & ~r_color_next_d;

  // Staging word with the incoming nibble merged in; out-of-range nibble leaves it unchanged
  always_comb begin
    w_merged = r_staging;
    for (int unsigned n = 0; n < NIBS; n++) begin
      if (w_nib == NIB_W'(n)) begin
        w_merged[n*4 +: 4] = bus.data;
      end
    end
  end

  // Acknowledge each accepted write one cycle later; held valid is accepted every other cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_accept;
    end
  end

  // Staging accumulates nibbles; the last nibble commits the merged word to the addressed entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_staging <= '0;
      for (int unsigned k = 0; k < NUM_PAL; k++) begin
        r_pal[k] <= '0;
      end
    end else if (w_accept && w_nib_ok) begin
      r_staging <= w_merged;
      if (w_last) begin
        r_pal[w_entry] <= w_merged;
      end
    end
  end

  // Previous input levels for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_swap_h_d     <= 1'b0;
      r_swap_v_d     <= 1'b0;
      r_color_next_d <= 1'b0;
    end else begin
      r_swap_h_d     <= i_swap_h;
      r_swap_v_d     <= i_swap_v;
      r_color_next_d <= i_color_next;
    end
  end

  // Mirror flags toggle on each swap rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flip_h <= 1'b0;
      r_flip_v <= 1'b0;
    end else begin
      if (w_swap_h_rise) r_flip_h <= ~r_flip_h;
      if (w_swap_v_rise) r_flip_v <= ~r_flip_v;
    end
  end

  // Per-channel palette index; NUM_PAL is a power of two so the increment wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_idx[i] <= PAL_W'(i % NUM_PAL);
      end
    end else if (w_color_next_rise) begin
      r_idx[i_channel] <= r_idx[i_channel] + PAL_W'(1);
    end
  end

  // Mirror sources are fixed per channel, so routing is a 4-way select among constant indices
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_route
    localparam int R    = gi / COLS;
    localparam int C    = gi % COLS;
    localparam int S_N  = R * COLS + C;
    localparam int S_H  = R * COLS + (COLS - 1 - C);
    localparam int S_V  = (ROWS - 1 - R) * COLS + C;
    localparam int S_HV = (ROWS - 1 - R) * COLS + (COLS - 1 - C);

    logic [COLOR_W+1:0] w_sum;
    logic [COLOR_W-1:0] w_y;

    // Select the mirrored source channel's palette colour
    always_comb begin
      w_raw[gi] = r_pal[r_idx[S_N]];
      case ({r_flip_v, r_flip_h})
        2'b00:   w_raw[gi] = r_pal[r_idx[S_N]];
        2'b01:   w_raw[gi] = r_pal[r_idx[S_H]];
        2'b10:   w_raw[gi] = r_pal[r_idx[S_V]];
        default: w_raw[gi] = r_pal[r_idx[S_HV]];
      endcase
    end

    assign w_sum = {2'b00, w_raw[gi][PIX_W-1 -: COLOR_W]}
                 + {1'b0,  w_raw[gi][2*COLOR_W-1 -: COLOR_W], 1'b0}
                 + {2'b00, w_raw[gi][COLOR_W-1:0]};
    assign w_y   = COLOR_W'(w_sum >> 2);

    // Apply the output colour mode
    always_comb begin
      w_out[gi] = w_raw[gi];
      case (w_mode)
        MODE_GRAY:      w_out[gi] = {w_y, w_y, w_y};
        MODE_INVERT:    w_out[gi] = ~w_raw[gi];
        MODE_REPLICATE: w_out[gi] = w_raw[0];
        default:        w_out[gi] = w_raw[gi];
      endcase
    end

    assign o_ch_flat[gi*PIX_W +: PIX_W] = r_ch[gi];
  end

  for (genvar gk = 0; gk < NUM_PAL; gk++) begin : g_pal_flat
    assign o_pal_flat[gk*PIX_W +: PIX_W] = r_pal[gk];
  end

  // Register the channel colours
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_ch[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_ch[i] <= w_out[i];
      end
    end
  end

endmodule

// File: tb/tb_color_palette_router.sv
// Directed bench for color_palette_router with hand-computed expectations.
module tb_color_palette_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        swap_h;
  logic        swap_v;
  logic        color_next;
  logic [1:0]  channel;
  logic [1:0]  mode;
  logic [191:0] pal_flat;
  logic [95:0]  ch_flat;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  color_palette_router_if #(.ADDR_W(6)) bus ();

  color_palette_router #(
    .NUM_PAL (8),
    .ROWS    (2),
    .COLS    (2),
    .COLOR_W (8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_swap_h     (swap_h),
    .i_swap_v     (swap_v),
    .i_color_next (color_next),
    .i_channel    (channel),
    .i_mode       (mode),
    .bus          (bus),
    .o_pal_flat   (pal_flat),
    .o_ch_flat    (ch_flat)
  );

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pal(input int k);
    return pal_flat[k*24 +: 24];
  endfunction

  function automatic logic [23:0] ch(input int i);
    return ch_flat[i*24 +: 24];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] entry, input logic [2:0] nib, input logic [3:0] d);
    bus.address = {entry, nib};
    bus.data    = d;
    bus.valid   = 1'b1;
    tick();
    bus.valid   = 1'b0;
    tick();
  endtask

  task automatic wrword(input logic [2:0] entry, input logic [23:0] w);
    for (int n = 0; n < 6; n++) begin
      wr(entry, 3'(n), w[n*4 +: 4]);
    end
  endtask

  task automatic pulse_cn(input logic [1:0] c);
    channel    = c;
    color_next = 1'b1;
    tick();
    color_next = 1'b0;
    tick();
  endtask

  task automatic pulse_swap(input logic h, input logic v);
    swap_h = h;
    swap_v = v;
    tick();
    swap_h = 1'b0;
    swap_v = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] word;
    rst = 1'b1; swap_h = 1'b0; swap_v = 1'b0; color_next = 1'b0;
    channel = '0; mode = 2'd0;
    bus.address = '0; bus.data = '0; bus.valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_pal", pal_flat, '0);
    chk("reset_ch",  ch_flat,  '0);
    chk("reset_ack", bus.ack,  1'b0);

    // Entry 2 = 0x123456, channel 0 advanced twice to index 2
    wrword(3'd2, 24'h123456);
    chk("pal2", pal(2), 24'h123456);
    pulse_cn(2'd0);
    pulse_cn(2'd0);
    tick();
    chk("ch0_idx2", ch(0), 24'h123456);
    chk("ch2_idx2", ch(2), 24'h123456);

    // Held valid: entry 1 = 0xFF8000, one accept every other cycle
    word = 24'hFF8000;
    bus.valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      bus.address = {3'd1, 3'(n)};
      bus.data    = word[n*4 +: 4];
      tick();
      chk($sformatf("hold_ack_hi%0d", n), bus.ack, 1'b1);
      if (n == 4) chk("pal1_pre_commit", pal(1), 24'h0);
      if (n == 5) begin
        chk("pal1_commit", pal(1), 24'hFF8000);
        chk("ch1_pre", ch(1), 24'h0);
      end
      tick();
      chk($sformatf("hold_ack_lo%0d", n), bus.ack, 1'b0);
    end
    chk("ch1_post", ch(1), 24'hFF8000);
    bus.address = {3'd1, 3'd6};
    bus.data    = 4'h5;
    tick();
    chk("nib6_ack", bus.ack, 1'b1);
    chk("nib6_pal", pal_flat, {96'h0, 24'h123456, 24'hFF8000, 24'h0});
    bus.valid = 1'b0;
    tick();

    // color_next held high: single advance of channel 1 (1 -> 2)
    channel = 2'd1;
    color_next = 1'b1;
    repeat (5) tick();
    color_next = 1'b0;
    tick();
    chk("cn_hold_ch1", ch(1), 24'h123456);
    repeat (5) pulse_cn(2'd1);
    chk("cn_idx7_ch1", ch(1), 24'h0);
    repeat (2) pulse_cn(2'd1);
    chk("cn_wrap_ch1", ch(1), 24'hFF8000);

    // Channel 0 back to index 0 (2 + 6 wraps to 0), then distinct colours
    repeat (6) pulse_cn(2'd0);
    wrword(3'd0, 24'h111111);
    wrword(3'd1, 24'h222222);
    wrword(3'd2, 24'h333333);
    wrword(3'd3, 24'h444444);
    chk("grid_base", ch_flat, {24'h444444, 24'h333333, 24'h222222, 24'h111111});
    pulse_swap(1'b1, 1'b0);
    chk("grid_h", ch_flat, {24'h333333, 24'h444444, 24'h111111, 24'h222222});
    pulse_swap(1'b0, 1'b1);
    chk("grid_hv", ch_flat, {24'h111111, 24'h222222, 24'h333333, 24'h444444});
    pulse_swap(1'b1, 1'b1);
    chk("grid_restore", ch_flat, {24'h444444, 24'h333333, 24'h222222, 24'h111111});

    // Output modes with channel 1 = 0xFF8000
    wrword(3'd1, 24'hFF8000);
    chk("mode0_ch1", ch(1), 24'hFF8000);
    mode = 2'd1; tick();
    chk("gray_ch1", ch(1), 24'h7F7F7F);
    chk("gray_ch0", ch(0), 24'h111111);
    mode = 2'd2; tick();
    chk("inv_ch1", ch(1), 24'h007FFF);
    chk("inv_ch0", ch(0), 24'hEEEEEE);
    mode = 2'd3; tick();
    chk("repl_all", ch_flat, {4{24'h111111}});
    mode = 2'd0; tick();

    // Reset mid-write clears staging; a write during reset is not acked
    wr(3'd0, 3'd0, 4'h7);
    wr(3'd0, 3'd1, 4'h7);
    wr(3'd0, 3'd2, 4'h7);
    rst = 1'b1;
    bus.address = {3'd0, 3'd0};
    bus.data    = 4'h9;
    bus.valid   = 1'b1;
    tick();
    chk("rst_ack", bus.ack, 1'b0);
    rst = 1'b0;
    bus.valid = 1'b0;
    tick();
    chk("rst_ack_after", bus.ack, 1'b0);
    wr(3'd0, 3'd3, 4'h1);
    wr(3'd0, 3'd4, 4'h2);
    wr(3'd0, 3'd5, 4'h3);
    chk("rst_pal", pal_flat, 192'h321000);
    chk("rst_ch", ch_flat, 96'h321000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
